// File: rtl/shift_led_right_pkg.sv
// Shared constants for the LED shift partitions (left and right variants).
// Both variants step at the same rate and reset to the same pattern.
package shift_led_right_pkg;

  localparam int LED_W           = 16;
  localparam int POS_W           = $clog2(LED_W);
  localparam int CLK_DIV_DEFAULT = 10_000_000;

  localparam logic [LED_W-1:0] LED_RESET_PAT = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_RESET     = POS_W'(LED_W-1);

  typedef enum logic [1:0] {
    STEP_SHIFT,
    STEP_WRAP,
    STEP_RECOVER
  } step_kind_e;

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/shift_led_right_if.sv
// Pin footprint of the LED shift partition, shared by both shift variants.
interface shift_led_right_if;
  import shift_led_right_pkg::*;

  logic             en;
  logic [LED_W-1:0] led;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             wrap;
  logic             err;

  modport master (output en, input led, pos, step, wrap, err);
  modport slave  (input en, output led, pos, step, wrap, err);

endinterface

// File: rtl/shift_led_right_led_tick_gen.sv
// Clock-enable divider: tick is high during the last enabled count of each
// period, so the consumer's register updates on the terminal-count edge.
module led_tick_gen
  import shift_led_right_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  output logic tick_o
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_led_right.sv
// Right-rotating single-LED pattern with position, step/wrap pulses and a
// sticky one-hot integrity flag for the static region to monitor.
module shift_led_right
  import shift_led_right_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input logic              sys_clk,
  input logic              rst,
  shift_led_right_if.slave led_if
);

  logic             tick;
  logic [LED_W-1:0] led_q, led_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  step_kind_e       kind;

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (led_if.en),
    .tick_o  (tick)
  );

  // A corrupted pattern is reloaded rather than shifted, so it never propagates.
  always_comb begin
    if (!is_onehot(led_q)) kind = STEP_RECOVER;
    else if (led_q[0])     kind = STEP_WRAP;
    else                   kind = STEP_SHIFT;
  end

  always_comb begin
    led_d  = led_q;
    pos_d  = pos_q;
    step_d = tick;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (tick) begin
      case (kind)
        STEP_SHIFT: begin
          led_d = led_q >> 1;
          pos_d = pos_q - 1'b1;
        end
        STEP_WRAP: begin
          led_d  = LED_RESET_PAT;
          pos_d  = POS_RESET;
          wrap_d = 1'b1;
        end
        default: begin
          led_d = LED_RESET_PAT;
          pos_d = POS_RESET;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led_q  <= LED_RESET_PAT;
      pos_q  <= POS_RESET;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      led_q  <= led_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign led_if.led  = led_q;
  assign led_if.pos  = pos_q;
  assign led_if.step = step_q;
  assign led_if.wrap = wrap_q;
  assign led_if.err  = err_q;

endmodule
